// File: rtl/ibex_pkg.sv
// Shared bus types for the Ibex data-side memory responder.
package ibex_pkg;

  parameter int unsigned BUS_DATA_W = 32;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } bus_resp_t;

  // Only in-range reads return data; writes and bus errors return zero.
  function automatic bus_resp_t make_resp(input logic we, input logic in_range,
                                          input logic [BUS_DATA_W-1:0] rd_word);
    bus_resp_t r;
    r.err   = ~in_range;
    r.rdata = (in_range && !we) ? rd_word : '0;
    return r;
  endfunction

endpackage

// File: rtl/ibex_bus_resp_delay.sv
// Fixed-latency shift pipeline carrying bus responses from accept to rvalid.
module ibex_bus_resp_delay
  import ibex_pkg::*;
#(
  parameter int unsigned Latency = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  input  bus_resp_t in_resp,
  output logic      out_valid,
  output bus_resp_t out_resp
);

  logic [Latency-1:0] valid_q;
  bus_resp_t          resp_q [Latency];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int unsigned s = 1; s < Latency; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    resp_q[0] <= in_resp;
    for (int unsigned s = 1; s < Latency; s++) begin
      resp_q[s] <= resp_q[s-1];
    end
  end

  assign out_valid = valid_q[Latency-1];
  assign out_resp  = resp_q[Latency-1];

endmodule

// File: rtl/ibex_data_mem_responder.sv
// Data-bus target for Ibex: grants under an outstanding limit, byte-enabled
// word RAM, and in-order responses a fixed number of cycles after grant.
module ibex_data_mem_responder
  import ibex_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [BUS_DATA_W-1:0] wdata_i,
  input  logic                  stall_i,
  output logic                  rvalid_o,
  output logic [BUS_DATA_W-1:0] rdata_o,
  output logic                  err_o
);

  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned AddrW = (MemWords > 1) ? $clog2(MemWords) : 1;

  logic [CntW-1:0]       outst_q;
  logic [29:0]           idx;
  logic [AddrW-1:0]      mem_addr;
  logic                  in_range;
  logic                  accept;
  logic [BUS_DATA_W-1:0] rd_word;
  bus_resp_t             acc_resp;
  bus_resp_t             out_resp;
  logic                  out_valid;
  logic [1:0]            unused_addr;

  (* ram_style = "distributed" *) logic [BUS_DATA_W-1:0] mem [MemWords];

  assign unused_addr = addr_i[1:0];
  assign idx         = addr_i[31:2];
  assign mem_addr    = idx[AddrW-1:0];
  assign in_range    = (32'(idx) < MemWords);

  assign gnt_o  = req_i & ~stall_i & ~rst_i & (outst_q < CntW'(MaxOutstanding));
  assign accept = req_i & gnt_o;

  // Single write port with per-byte enables; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[mem_addr][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read is captured into the first pipeline stage at the accept edge.
  assign rd_word  = mem[mem_addr];
  assign acc_resp = make_resp(we_i, in_range, rd_word);

  ibex_bus_resp_delay #(
    .Latency(RespLatency)
  ) u_resp_delay (
    .clk      (clk_i),
    .rst      (rst_i),
    .in_valid (accept),
    .in_resp  (acc_resp),
    .out_valid(out_valid),
    .out_resp (out_resp)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q <= '0;
    end else begin
      case ({accept, out_valid})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  assign rvalid_o = out_valid;
  assign rdata_o  = out_valid ? out_resp.rdata : '0;
  assign err_o    = out_valid ? out_resp.err : 1'b0;

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// Scoreboard bench for ibex_data_mem_responder with default parameters.
module tb_ibex_data_mem_responder;

  localparam int MEM_WORDS = 1024;
  localparam int LAT       = 1;
  localparam int MAX_OUT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [int];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          rv_count = 0;
  int          max_outst = 0;

  ibex_data_mem_responder #(
    .MemWords(MEM_WORDS),
    .RespLatency(LAT),
    .MaxOutstanding(MAX_OUT)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .gnt_o   (gnt),
    .addr_i  (addr),
    .we_i    (we),
    .be_i    (be),
    .wdata_i (wdata),
    .stall_i (stall),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .err_o   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant model, counter tracking, response scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t        e;
      logic        exp_gnt;
      int          widx;
      logic [31:0] m;
      exp_gnt = req && !stall && (sb.size() < MAX_OUT);
      checks++;
      if (gnt !== exp_gnt) begin
        failures++;
        $display("FAIL gnt_rule t=%0t got=%b want=%b", $time, gnt, exp_gnt);
      end
      checks++;
      if (int'(dut.outst_q) != sb.size()) begin
        failures++;
        $display("FAIL outst_count t=%0t got=%0d want=%0d", $time, dut.outst_q, sb.size());
      end
      if (int'(dut.outst_q) > max_outst) max_outst = int'(dut.outst_q);
      if (rvalid) begin
        rv_count++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rvalid t=%0t rdata=%h err=%b", $time, rdata, err);
        end else begin
          e = sb.pop_front();
          if (rdata !== e.rdata || err !== e.err || cyc != e.due) begin
            failures++;
            $display("FAIL resp t=%0t got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                     $time, rdata, err, cyc, e.rdata, e.err, e.due);
          end else begin
            $display("resp ok t=%0t rdata=%h err=%b", $time, rdata, err);
          end
        end
      end else begin
        checks++;
        if (rdata !== 32'h0 || err !== 1'b0) begin
          failures++;
          $display("FAIL idle_outputs t=%0t got rdata=%h err=%b want 0/0", $time, rdata, err);
        end
      end
      if (req && gnt) begin
        widx = int'(addr[31:2]);
        e.due = cyc + LAT;
        if (widx >= MEM_WORDS) begin
          e.err = 1'b1;
          e.rdata = 32'h0;
        end else if (we) begin
          e.err = 1'b0;
          e.rdata = 32'h0;
          m = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
          for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wdata[8*b +: 8];
          model_mem[widx] = m;
        end else begin
          e.err = 1'b0;
          e.rdata = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
        end
        sb.push_back(e);
        $display("accept t=%0t addr=%h we=%b be=%b wdata=%h", $time, addr, we, be, wdata);
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d);
    int n;
    req = 1'b1; addr = a; we = w; be = b; wdata = d; n = 0;
    @(negedge clk);
    while (!gnt && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!gnt) begin
      failures++;
      $display("FAIL grant_timeout addr=%h got gnt=%b want 1", a, gnt);
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic check_read_now(input string name, input logic [31:0] want_d, input logic want_e);
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== want_d || err !== want_e) begin
      failures++;
      $display("FAIL %s got rvalid=%b rdata=%h err=%b want rvalid=1 rdata=%h err=%b",
               name, rvalid, rdata, err, want_d, want_e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req = 1'b1; addr = 32'h0; we = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (gnt !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 ||
          dut.outst_q !== '0) begin
        failures++;
        $display("FAIL reset_state got gnt=%b rvalid=%b rdata=%h err=%b outst=%0d want all 0",
                 gnt, rvalid, rdata, err, dut.outst_q);
      end
    end
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_req(32'h0, 1'b1, 4'hF, 32'hCAFEF00D);
    do_req(32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    do_req(32'h10, 1'b0, 4'h0, 32'h0);
    check_read_now("full_write_read", 32'hDEADBEEF, 1'b0);
    wait_drain();
  endtask

  task automatic test_partial_write();
    do_req(32'h10, 1'b1, 4'b0101, 32'h11223344);
    do_req(32'h10, 1'b0, 4'h0, 32'h0);
    check_read_now("partial_write_read", 32'hDE22BE44, 1'b0);
    wait_drain();
  endtask

  task automatic test_out_of_range();
    do_req(MEM_WORDS * 4, 1'b0, 4'h0, 32'h0);
    check_read_now("oor_read", 32'h0, 1'b1);
    do_req(MEM_WORDS * 4, 1'b1, 4'hF, 32'hFFFFFFFF);
    do_req(32'h10, 1'b1, 4'b0000, 32'hFFFFFFFF);
    do_req(32'h0, 1'b0, 4'h0, 32'h0);
    check_read_now("word0_after_oor", 32'hCAFEF00D, 1'b0);
    do_req(32'h10, 1'b0, 4'h0, 32'h0);
    check_read_now("be_zero_no_change", 32'hDE22BE44, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int g, n, rv0;
    for (int i = 0; i < 6; i++) do_req(32'h100 + 4 * i, 1'b1, 4'hF, 32'hA5000000 + i * 32'h00010203);
    wait_drain();
    rv0 = rv_count; max_outst = 0;
    g = 0; n = 0;
    req = 1'b1; we = 1'b0; addr = 32'h100;
    while (g < 6 && n < 40) begin
      @(negedge clk);
      if (gnt) g++;
      @(posedge clk); #1;
      n++;
      addr = 32'h100 + 4 * g;
    end
    req = 1'b0;
    checks++;
    if (g != 6) begin
      failures++;
      $display("FAIL b2b_grants got=%0d want=6", g);
    end
    wait_drain();
    checks++;
    if (rv_count - rv0 != 6) begin
      failures++;
      $display("FAIL b2b_rvalid_count got=%0d want=6", rv_count - rv0);
    end
    checks++;
    if (max_outst > MAX_OUT) begin
      failures++;
      $display("FAIL b2b_outstanding got=%0d want<=%0d", max_outst, MAX_OUT);
    end
  endtask

  task automatic test_stall();
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1) begin
      failures++;
      $display("FAIL stall_pre_grant got=%b want=1", gnt);
    end
    @(posedge clk); #1;
    stall = 1'b1; addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 1'b0) begin
        failures++;
        $display("FAIL stall_gnt cycle=%0d got=%b want=0", i, gnt);
      end
      if (i == 0) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDE22BE44) begin
          failures++;
          $display("FAIL stall_inflight got rvalid=%b rdata=%h want 1/DE22BE44", rvalid, rdata);
        end
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_grant got=%b want=1", gnt);
    end
    @(posedge clk); #1;
    req = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_midop();
    do_req(32'h20, 1'b1, 4'hF, 32'h5A5A1234);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || dut.outst_q !== '0) begin
      failures++;
      $display("FAIL midop_reset got rvalid=%b outst=%0d want 0/0", rvalid, dut.outst_q);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0 || dut.outst_q !== '0) begin
        failures++;
        $display("FAIL post_reset_quiet got rvalid=%b outst=%0d want 0/0", rvalid, dut.outst_q);
      end
      @(posedge clk); #1;
    end
    do_req(32'h20, 1'b0, 4'h0, 32'h0);
    check_read_now("write_persists_reset", 32'h5A5A1234, 1'b0);
    do_req(32'h10, 1'b0, 4'h0, 32'h0);
    check_read_now("old_data_persists_reset", 32'hDE22BE44, 1'b0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_out_of_range();
    test_back_to_back();
    test_stall();
    test_reset_midop();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_pending got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
